// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment encodings and BCD decode shared by the seg7 counter
package seg7_pkg;

    // Bit positions inside the 8-bit {A,B,C,D,E,F,G,DP} segment bus
    localparam int SEG_A  = 7;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [6:0] SEG7_0     = 7'b1111110;
    localparam logic [6:0] SEG7_1     = 7'b0110000;
    localparam logic [6:0] SEG7_2     = 7'b1101101;
    localparam logic [6:0] SEG7_3     = 7'b1111001;
    localparam logic [6:0] SEG7_4     = 7'b0110011;
    localparam logic [6:0] SEG7_5     = 7'b1011011;
    localparam logic [6:0] SEG7_6     = 7'b1011111;
    localparam logic [6:0] SEG7_7     = 7'b1110000;
    localparam logic [6:0] SEG7_8     = 7'b1111111;
    localparam logic [6:0] SEG7_9     = 7'b1111011;
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG7_0;
            4'd1:    return SEG7_1;
            4'd2:    return SEG7_2;
            4'd3:    return SEG7_3;
            4'd4:    return SEG7_4;
            4'd5:    return SEG7_5;
            4'd6:    return SEG7_6;
            4'd7:    return SEG7_7;
            4'd8:    return SEG7_8;
            4'd9:    return SEG7_9;
            default: return SEG7_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one up/down BCD digit with clear, load and ripple carry/borrow
module bcd_digit
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       up,
    input  logic       step,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       carry_out,
    output logic       borrow_out
);

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= (load_val > BCD_MAX) ? 4'd0 : load_val;
        end else if (step) begin
            if (up) begin
                value <= (value == BCD_MAX) ? 4'd0 : value + 4'd1;
            end else begin
                value <= (value == 4'd0) ? BCD_MAX : value - 4'd1;
            end
        end
    end

    // Combinational so the whole chain settles within the tick cycle
    assign carry_out  = step & up & (value == BCD_MAX);
    assign borrow_out = step & ~up & (value == 4'd0);

endmodule

// File: rtl/seg7_multidigit_counter.sv
// rtl/seg7_multidigit_counter.sv - N-digit BCD up/down counter with multiplexed 7-segment drive
module seg7_multidigit_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 16000000,
    parameter int SCAN_DIV     = 4000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    CLR,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
    input  logic                    BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   DP_SEL,
    output logic [4*NUM_DIGITS-1:0] COUNT,
    output logic                    WRAP,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIG
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // XOR masks that also serve as the "all off" reset levels
    localparam logic [7:0]            SEG_OFF = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{COMMON_ANODE != 0}};

    logic [PW-1:0]       presc;
    logic [SW-1:0]       dwell;
    logic [IW-1:0]       idx;
    logic                tick;
    logic [NUM_DIGITS:0] chain;
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] borrow;

    assign tick     = EN && (presc == PRESC_LAST);
    assign chain[0] = tick & ~CLR & ~LOAD;

    always_ff @(posedge CLK) begin
        if (RST || CLR || LOAD) begin
            presc <= '0;
        end else if (EN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (CLK),
            .up         (UP),
            .step       (chain[g]),
            .clr        (RST | CLR),
            .load       (LOAD),
            .load_val   (LOAD_VAL[4*g +: 4]),
            .value      (COUNT[4*g +: 4]),
            .carry_out  (carry[g]),
            .borrow_out (borrow[g])
        );
        assign chain[g+1] = carry[g] | borrow[g];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= chain[NUM_DIGITS];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dwell <= '0;
            idx   <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]            nib;
    logic                  nib_blank;
    logic                  nib_dp;
    logic                  upper_zero;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    // Walk from the most significant digit so each position knows whether everything above it is zero
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        nib        = 4'd0;
        nib_blank  = 1'b0;
        nib_dp     = 1'b0;
        dig_raw    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (COUNT[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LZ && (i != 0) && upper_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib        = COUNT[4*i +: 4];
                nib_blank  = blank[i];
                nib_dp     = DP_SEL[i];
                dig_raw[i] = 1'b1;
            end
        end
        seg_raw                = '0;
        seg_raw[SEG_A:SEG_G]   = nib_blank ? SEG7_BLANK : seg7_decode(nib);
        seg_raw[SEG_DP]        = nib_dp;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG <= SEG_OFF;
            DIG <= DIG_OFF;
        end else begin
            SEG <= seg_raw ^ SEG_OFF;
            DIG <= dig_raw ^ DIG_OFF;
        end
    end

endmodule

// File: doc/seg7_multidigit_counter.md
# seg7_multidigit_counter

Parametrised N-digit BCD up/down counter driving a time-multiplexed 7-segment display on the TinyFPGA BX board. It is the multi-digit successor of the single-digit decimal counter demo. It adds direction control, load, clear, a wrap pulse, decimal-point selection, leading-zero blanking and selectable display polarity. It sits directly between the board pins and any logic that wants to show or step a decimal value.

## Interface
Parameters:
- NUM_DIGITS, 4: number of BCD digits and display digit selects; ≥1.
- TICK_DIV, 16000000: CLK cycles per count step; ≥1.
- SCAN_DIV, 4000: CLK cycles each digit is driven; ≥1.
- COMMON_ANODE, 0: 1 inverts both SEG and DIG at the output register.

Ports:
- CLK  in  1  16 MHz system clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  prescaler and counting enable.
- UP  in  1  count direction: 1 = up, 0 = down.
- CLR  in  1  synchronous clear of the count value.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  4*NUM_DIGITS  BCD load value; nibble 0 is the least significant digit.
- BLANK_LZ  in  1  leading-zero blanking enable.
- DP_SEL  in  NUM_DIGITS  decimal point lit on digit i when bit i = 1.
- COUNT  out  4*NUM_DIGITS  current BCD value.
- WRAP  out  1  one-cycle pulse on overflow or underflow.
- SEG  out  8  {A,B,C,D,E,F,G,DP}, with A as the MSB.
- DIG  out  NUM_DIGITS  one-hot digit select; bit 0 drives the rightmost (least significant) digit.

## Operation
- Prescaler runs 0..TICK_DIV-1 while EN=1 and holds while EN=0. A tick occurs in the cycle when EN=1 and the prescaler equals TICK_DIV-1. Prescaler width is max(1,$clog2(TICK_DIV)).
- Priority on each edge: RST > CLR > LOAD > tick.
  - CLR sets COUNT=0 and prescaler=0.
  - LOAD sets COUNT=LOAD_VAL and prescaler=0. Any nibble >9 loads as 0.
- On a tick, up counting: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit. All-9s becomes all-0s and sets WRAP=1.
- On a tick, down counting: a digit at 0 goes to 9 and borrows from the next digit. All-0s becomes all-9s and sets WRAP=1.
- Scan: a dwell counter runs 0..SCAN_DIV-1. At terminal count the digit index advances, wrapping from NUM_DIGITS-1 to 0. Scanning runs regardless of EN.
- Digit i is blank (segments A–G off) when BLANK_LZ=1, i≠0, and digits i..NUM_DIGITS-1 are all 0. DP is still driven from DP_SEL[i] on a blanked digit.
- Segment patterns for 0–9: 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110 (A..G, DP=0 before DP_SEL is applied).
- COMMON_ANODE=1 inverts all SEG and DIG bits.

## Timing
- Reset values (after polarity is applied):
  - COUNT=0, WRAP=0.
  - Prescaler, dwell counter and digit index all 0.
  - SEG=all off, DIG=all off.
- COUNT, WRAP, SEG and DIG are all registered outputs.
- COUNT changes on the clock edge that samples a tick, CLR or LOAD. WRAP is high during exactly the cycle in which COUNT first shows the wrapped value.
- With EN held high, ticks occur every TICK_DIV cycles. With TICK_DIV=1, a tick occurs on every enabled cycle.
- SEG/DIG reflect the digit index and COUNT with 1 cycle of latency. SEG and DIG always change on the same edge, so no mixed-digit frame appears.
- After RST deasserts, digit 0 is driven from the first edge onward. Each digit is held for SCAN_DIV cycles, so a full frame takes NUM_DIGITS*SCAN_DIV cycles.
- RST during counting forces all reset values on the next edge. EN low mid-count freezes the prescaler phase, and resuming does not lose the partial count.

## Structure
- Package seg7_pkg:
  - segment pattern constants for 0–9 and blank;
  - seg7_decode function (4-bit → 7 bits);
  - the bit order of {A..G,DP}.
- Sub-module bcd_digit: one BCD digit with inputs up, step, clr, load, load_val. It outputs value, carry_out (9→0 going up) and borrow_out (0→9 going down).
- The top module chains NUM_DIGITS instances in a generate loop and contains the prescaler, scan logic, blanking and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated.
- Reset, then EN=1, UP=1: COUNT steps 0000→0001 every 4 cycles. The step from 0009 goes to 0010. EN=0 for 3 cycles delays the next step by exactly 3 cycles.
- LOAD 9999, UP=1: the next tick (4 cycles after load) gives COUNT=0000 with WRAP=1 for one cycle. UP=0 from 0000 gives 9999 with WRAP=1. UP=0 from 0100 gives 0099 with WRAP=0.
- LOAD 0007, DP_SEL=0010, BLANK_LZ=1:
  - DIG sequence 0001,0010,0100,1000, each held 2 cycles.
  - Digit 0 SEG=11100000; digit 1 SEG=00000001; digits 2–3 SEG=00000000.
  - With BLANK_LZ=0: digits 2–3 show 11111100 and digit 1 shows 11111101.
- Priority and load checks:
  - LOAD with LOAD_VAL=0x3C51 gives COUNT=0x3051.
  - CLR and LOAD asserted together give COUNT=0000.
  - CLR coinciding with a tick gives 0000 and WRAP=0.
- COMMON_ANODE=1: while digit 0 shows 0, DIG=1110 and SEG=00000011. During RST, SEG=11111111 and DIG=1111.
- RST asserted mid-count at 0042: the next edge gives COUNT=0000, WRAP=0, digit index 0. The first tick after release arrives exactly 4 cycles later.
